// File: rtl/reg_debug_display_pkg.sv
// Shared constants for the register-file debug display: digit/register counts and
// active-low 7-segment patterns ordered {g,f,e,d,c,b,a}.
package reg_debug_display_pkg;

  localparam int NDIGITS = 8;
  localparam int NREGS   = 32;
  localparam int IDX_W   = $clog2(NREGS);
  localparam int DIG_W   = $clog2(NDIGITS);

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/reg_debug_display_if.sv
// Register-file debug read port. No valid/ready: the reader drives ReadReg and the
// regfile answers combinationally on RegData for that same index, every cycle.
interface reg_debug_display_if;
  import reg_debug_display_pkg::*;

  logic [IDX_W-1:0] ReadReg;
  logic [31:0]      RegData;

  modport master (output ReadReg, input RegData);
  modport slave  (input ReadReg, output RegData);

endinterface

// File: rtl/reg_debug_display_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, and a single-cycle
// pulse when a new high level is accepted.
module btn_debounce #(
  parameter int DEBOUNCE = 1000000
) (
  input  logic CLK,
  input  logic Reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [1:0]    sync_q;
  logic          btn_s;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  assign btn_s   = sync_q[1];
  assign pulse_o = pulse_q;

  // Counter runs only while the sampled level disagrees with the accepted one, so
  // any return to the accepted level before the limit discards the glitch.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (btn_s != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        stable_d = btn_s;
        pulse_d  = btn_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

endmodule

// File: rtl/reg_debug_display.sv
// Selects a register on the regfile debug port and shows its value as 8 hex digits on a
// multiplexed active-low 7-segment display; index stepped by buttons or auto-scan.
module reg_debug_display
  import reg_debug_display_pkg::*;
#(
  parameter int DIGIT_DIV  = 100000,
  parameter int DEBOUNCE   = 1000000,
  parameter int AUTO_TICKS = 50000000
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       BtnNext,
  input  logic                       BtnPrev,
  input  logic                       AutoScan,
  reg_debug_display_if.master        dbg,
  output logic [NDIGITS-1:0]         AN,
  output logic [6:0]                 SEG
);

  localparam int DIV_W  = (DIGIT_DIV  > 1) ? $clog2(DIGIT_DIV)  : 1;
  localparam int AUTO_W = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = SEG_0;  4'h1: hex7 = SEG_1;  4'h2: hex7 = SEG_2;  4'h3: hex7 = SEG_3;
      4'h4: hex7 = SEG_4;  4'h5: hex7 = SEG_5;  4'h6: hex7 = SEG_6;  4'h7: hex7 = SEG_7;
      4'h8: hex7 = SEG_8;  4'h9: hex7 = SEG_9;  4'hA: hex7 = SEG_A;  4'hB: hex7 = SEG_B;
      4'hC: hex7 = SEG_C;  4'hD: hex7 = SEG_D;  4'hE: hex7 = SEG_E;  default: hex7 = SEG_F;
    endcase
  endfunction

  logic next_p, prev_p;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_next (
    .CLK(CLK), .Reset(Reset), .btn_i(BtnNext), .pulse_o(next_p)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_prev (
    .CLK(CLK), .Reset(Reset), .btn_i(BtnPrev), .pulse_o(prev_p)
  );

  logic [1:0]          auto_sync_q;
  logic                auto_s;
  logic [AUTO_W-1:0]   auto_cnt_q, auto_cnt_d;
  logic                auto_tc;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                div_tc;
  logic [DIG_W-1:0]    digit_q, digit_d;
  logic                frame_end;
  logic [31:0]         show_q, show_d;
  logic [NDIGITS-1:0]  an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  assign auto_s      = auto_sync_q[1];
  assign auto_tc     = auto_s && (auto_cnt_q == AUTO_W'(AUTO_TICKS - 1));
  assign div_tc      = (div_q == DIV_W'(DIGIT_DIV - 1));
  assign frame_end   = div_tc && (digit_q == DIG_W'(NDIGITS - 1));
  assign dbg.ReadReg = idx_q;
  assign AN          = an_q;
  assign SEG         = seg_q;

  // Index: auto-scan owns the index while enabled; simultaneous Next+Prev cancel.
  always_comb begin
    auto_cnt_d = '0;
    idx_d      = idx_q;
    if (auto_s) begin
      if (auto_tc) idx_d = idx_q + IDX_W'(1);
      else         auto_cnt_d = auto_cnt_q + AUTO_W'(1);
    end else if (next_p && !prev_p) begin
      idx_d = idx_q + IDX_W'(1);
    end else if (prev_p && !next_p) begin
      idx_d = idx_q - IDX_W'(1);
    end
  end

  // Scan: the shown value is latched only on the 7->0 digit wrap so a frame is coherent.
  always_comb begin
    div_d   = div_tc ? '0 : div_q + DIV_W'(1);
    digit_d = div_tc ? digit_q + DIG_W'(1) : digit_q;
    show_d  = frame_end ? dbg.RegData : show_q;
    an_d    = ~(NDIGITS'(1) << digit_q);
    seg_d   = hex7(show_q[{digit_q, 2'b00} +: 4]);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      auto_sync_q <= 2'b00;
      auto_cnt_q  <= '0;
      idx_q       <= '0;
      div_q       <= '0;
      digit_q     <= '0;
      show_q      <= '0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      auto_sync_q <= {auto_sync_q[0], AutoScan};
      auto_cnt_q  <= auto_cnt_d;
      idx_q       <= idx_d;
      div_q       <= div_d;
      digit_q     <= digit_d;
      show_q      <= show_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

endmodule

// File: tb/tb_reg_debug_display.sv
// Bench for reg_debug_display with small timing parameters; a per-cycle display model
// and an index model track the expected outputs.
module tb_reg_debug_display;

  localparam int DIGIT_DIV  = 4;
  localparam int DEBOUNCE   = 3;
  localparam int AUTO_TICKS = 16;
  localparam int FRAME      = DIGIT_DIV * 8;
  localparam int SYNC_LAT   = 2;

  logic CLK, Reset, BtnNext, BtnPrev, AutoScan;
  logic [7:0] AN;
  logic [6:0] SEG;
  logic [31:0] mem [32];

  int tests = 0;
  int fails = 0;

  reg_debug_display_if dbg_if ();
  assign dbg_if.RegData = mem[dbg_if.ReadReg];

  reg_debug_display #(
    .DIGIT_DIV(DIGIT_DIV), .DEBOUNCE(DEBOUNCE), .AUTO_TICKS(AUTO_TICKS)
  ) dut (
    .CLK(CLK), .Reset(Reset), .BtnNext(BtnNext), .BtnPrev(BtnPrev),
    .AutoScan(AutoScan), .dbg(dbg_if), .AN(AN), .SEG(SEG)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Display model: k = rising edges since reset release; digit lit after edge k is
  // ((k-1)/DIGIT_DIV)%8; the shown word is whatever RegData held at each edge k%FRAME==0.
  int          k = 0;
  logic [31:0] shown_m;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  bit          mon_en = 0;

  always @(posedge CLK) begin
    int d;
    if (!Reset) begin
      k       = 0;
      shown_m = '0;
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
    end else begin
      d       = (k / DIGIT_DIV) % 8;
      exp_an  = ~(8'h01 << d);
      exp_seg = hex_tbl[(shown_m >> (4 * d)) & 32'hF];
      k++;
      if (k % FRAME == 0) shown_m = dbg_if.RegData;
    end
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      check("an_scan",  {24'h0, AN},  {24'h0, Reset ? exp_an  : 8'hFF});
      check("seg_scan", {25'h0, SEG}, {25'h0, Reset ? exp_seg : 7'h7F});
    end
  end

  // driver tasks
  int idx_m = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input bit nxt, input bit prv, input int len);
    BtnNext = nxt;
    BtnPrev = prv;
    tick(len);
    BtnNext = 1'b0;
    BtnPrev = 1'b0;
    tick(12);
    if (len >= DEBOUNCE && nxt && !prv) idx_m = (idx_m + 1) % 32;
    if (len >= DEBOUNCE && prv && !nxt) idx_m = (idx_m + 31) % 32;
  endtask

  task automatic goto_k(input int target);
    int guard = 0;
    while (k != target && guard < 4000) begin
      @(negedge CLK);
      guard++;
    end
    check("goto_k_reached", k, target);
  endtask

  // Edges from a change of AutoScan (made at a negedge) until ReadReg moves.
  task automatic count_step(output int n, input bit press_during);
    n = 0;
    while (dbg_if.ReadReg === 5'(idx_m) && n < 100) begin
      BtnNext = press_during && (n < 6);
      @(negedge CLK);
      n++;
    end
    BtnNext = 1'b0;
  endtask

  initial begin
    int n, kb, kind, len;
    Reset = 1'b1; BtnNext = 1'b0; BtnPrev = 1'b0; AutoScan = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h0;
    #1 Reset = 1'b0;
    tick(3);

    // reset state
    check("rst_readreg", {27'h0, dbg_if.ReadReg}, 32'h0);
    check("rst_an", {24'h0, AN}, 32'hFF);
    check("rst_seg", {25'h0, SEG}, 32'h7F);
    mon_en = 1;
    Reset = 1'b1;
    tick(1);
    check("first_an", {24'h0, AN}, 32'hFE);
    check("first_seg", {25'h0, SEG}, 32'h40);
    goto_k(29);
    check("frame1_last_an", {24'h0, AN}, 32'h7F);
    check("frame1_last_seg", {25'h0, SEG}, 32'h40);

    // debounce: short pulse rejected, long press gives one step
    press(1, 0, 2);
    check("short_press", {27'h0, dbg_if.ReadReg}, 32'(idx_m));
    press(1, 0, 10);
    check("long_press", {27'h0, dbg_if.ReadReg}, 32'd1);

    // wrap both ways, simultaneous press cancels
    press(0, 1, 5);
    check("prev_to_0", {27'h0, dbg_if.ReadReg}, 32'd0);
    press(0, 1, 5);
    check("prev_wrap_31", {27'h0, dbg_if.ReadReg}, 32'd31);
    press(1, 0, 5);
    check("next_wrap_0", {27'h0, dbg_if.ReadReg}, 32'd0);
    press(1, 1, 6);
    check("both_unchanged", {27'h0, dbg_if.ReadReg}, 32'(idx_m));

    // frame capture and mid-frame coherence
    kb = ((k / FRAME) + 1) * FRAME;
    mem[idx_m] = 32'h1234ABCD;
    goto_k(kb + 1);
    check("cap_d_an", {24'h0, AN}, 32'hFE);
    check("cap_d_seg", {25'h0, SEG}, 32'h21);
    goto_k(kb + 29);
    check("cap_1_an", {24'h0, AN}, 32'h7F);
    check("cap_1_seg", {25'h0, SEG}, 32'h79);
    goto_k(kb + FRAME + 8);
    mem[idx_m] = 32'h55555557;
    goto_k(kb + FRAME + 13);
    check("midframe_hold_seg", {25'h0, SEG}, 32'h08);
    goto_k(kb + 2 * FRAME + 1);
    check("next_frame_seg", {25'h0, SEG}, 32'h78);

    // randomized button walk against the index model
    for (int i = 0; i < 14; i++) begin
      kind = $urandom_range(0, 2);
      len  = $urandom_range(1, 8);
      press(kind != 1, kind != 0, len);
      check("rand_walk", {27'h0, dbg_if.ReadReg}, 32'(idx_m));
      if ($urandom_range(0, 3) == 0) tick(FRAME + $urandom_range(0, 7));
    end

    // auto-scan: first step AUTO_TICKS after the synchronised rise, then every AUTO_TICKS
    AutoScan = 1'b1;
    count_step(n, 1'b0);
    idx_m = (idx_m + 1) % 32;
    check("auto_first_delay", n, AUTO_TICKS + SYNC_LAT);
    check("auto_first_idx", {27'h0, dbg_if.ReadReg}, 32'(idx_m));
    count_step(n, 1'b1);
    idx_m = (idx_m + 1) % 32;
    check("auto_period_press_ignored", n, AUTO_TICKS);
    check("auto_second_idx", {27'h0, dbg_if.ReadReg}, 32'(idx_m));
    AutoScan = 1'b0;
    tick(30);
    check("auto_off_hold", {27'h0, dbg_if.ReadReg}, 32'(idx_m));
    AutoScan = 1'b1;
    count_step(n, 1'b0);
    idx_m = (idx_m + 1) % 32;
    AutoScan = 1'b0;
    check("auto_restart_delay", n, AUTO_TICKS + SYNC_LAT);
    check("auto_restart_idx", {27'h0, dbg_if.ReadReg}, 32'(idx_m));
    tick(FRAME + 5);

    // asynchronous reset mid-frame
    @(posedge CLK);
    #2 Reset = 1'b0;
    #1;
    check("async_rst_an", {24'h0, AN}, 32'hFF);
    check("async_rst_seg", {25'h0, SEG}, 32'h7F);
    check("async_rst_readreg", {27'h0, dbg_if.ReadReg}, 32'h0);
    idx_m = 0;
    tick(2);
    Reset = 1'b1;
    tick(1);
    check("post_rst_an", {24'h0, AN}, 32'hFE);
    tick(FRAME);

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
